// File: rtl/cpu_pkg.sv
// Shared types and helpers for the CPU run monitor: run-state encoding,
// default PC width and a PC-bus slicing helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } run_state_t;

  localparam int PC_W_DEFAULT = 16;
  localparam int MAX_CORES    = 16;
  localparam int MAX_PC_W     = 64;
  localparam int PC_BUS_MAX   = MAX_CORES * MAX_PC_W;

  // Extracts core idx's PC from a zero-extended bus; bits at or above width are cleared.
  function automatic logic [MAX_PC_W-1:0] pc_slice(input logic [PC_BUS_MAX-1:0] bus,
                                                    input int idx, input int width);
    logic [PC_BUS_MAX-1:0] shifted;
    logic [MAX_PC_W-1:0]   r;
    shifted = bus >> (idx * width);
    r = shifted[MAX_PC_W-1:0];
    for (int b = 0; b < MAX_PC_W; b++) begin
      if (b >= width) r[b] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Core-side bundle of the run monitor: reset to the cores, per-core halt levels and PCs.
interface cpu_run_monitor_if
  import cpu_pkg::*;
#(
  parameter int NUM_CORES = 1,
  parameter int PC_W      = PC_W_DEFAULT
);
  logic                      core_rst_n;
  logic [NUM_CORES-1:0]      hlt;
  logic [NUM_CORES*PC_W-1:0] pc;

  modport master (output core_rst_n, input hlt, input pc);
  modport slave  (input core_rst_n, output hlt, output pc);
endinterface

// File: rtl/halt_capture.sv
// Per-core halt latch: sticky halted flag plus the PC seen on the first halting RUN cycle.
module halt_capture #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            hlt,
  input  logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [PC_W-1:0] pc_cap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
      pc_cap <= '0;
    end else if (clr) begin
      halted <= 1'b0;
      pc_cap <= '0;
    end else if (en && hlt && !halted) begin
      halted <= 1'b1;
      pc_cap <= pc;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller: sequences core reset, counts RUN cycles, collects per-core halts,
// drains, and flags a watchdog timeout.
module cpu_run_monitor
  import cpu_pkg::*;
#(
  parameter int NUM_CORES    = 1,
  parameter int PC_W         = PC_W_DEFAULT,
  parameter int RST_HOLD     = 2,
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          timeout_limit,
  cpu_run_monitor_if.master         core,
  output logic                      running,
  output logic                      done,
  output logic                      timed_out,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [NUM_CORES-1:0]      halt_mask,
  output logic [NUM_CORES*PC_W-1:0] halt_pc
);

  localparam int RST_CNT_W = $clog2(RST_HOLD + 1);
  localparam int DRN_W     = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_HOLD - 1);
  localparam logic [DRN_W-1:0]     DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  run_state_t           state_q, state_d;
  logic [RST_CNT_W-1:0] rst_cnt_q;
  logic [DRN_W-1:0]     drain_cnt_q;
  logic                 core_rst_q;
  logic                 launch;
  logic                 wd_fire;
  logic                 capture_en;
  logic                 all_halted;
  logic                 wd_expired;
  logic [CNT_W:0]       count_next;
  logic [PC_BUS_MAX-1:0] pc_bus;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign capture_en = (state_q == S_RUN);
  // Bits set on this edge count too, so a halt on the final cycle ends the run immediately.
  assign all_halted = &(halt_mask | core.hlt);
  assign count_next = {1'b0, cycle_count} + (CNT_W + 1)'(1);
  assign wd_expired = (timeout_limit != '0) && (count_next >= {1'b0, timeout_limit});
  assign pc_bus     = PC_BUS_MAX'(core.pc);
  assign core.core_rst_n = core_rst_q;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    wd_fire = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RESET;
          launch  = 1'b1;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (all_halted) begin
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else if (wd_expired) begin
          state_d = S_DONE;
          wd_fire = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRN_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      drain_cnt_q <= '0;
      cycle_count <= '0;
      core_rst_q  <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
      running    <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done       <= (state_d == S_DONE);

      if (launch)       timed_out <= 1'b0;
      else if (wd_fire) timed_out <= 1'b1;

      if (launch)                   rst_cnt_q <= '0;
      else if (state_q == S_RESET)  rst_cnt_q <= rst_cnt_q + RST_CNT_W'(1);

      if (state_q == S_DRAIN) drain_cnt_q <= drain_cnt_q + DRN_W'(1);
      else                    drain_cnt_q <= '0;

      if (launch)                 cycle_count <= '0;
      else if (state_q == S_RUN)  cycle_count <= sat_inc(cycle_count);
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic [PC_W-1:0] pc_now;
    assign pc_now = PC_W'(pc_slice(pc_bus, i, PC_W));

    halt_capture #(.PC_W(PC_W)) u_cap (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (launch),
      .en     (capture_en),
      .hlt    (core.hlt[i]),
      .pc     (pc_now),
      .halted (halt_mask[i]),
      .pc_cap (halt_pc[i*PC_W +: PC_W])
    );
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: runs are described by per-core halt cycles and a limit,
// a run-level model predicts the outcome, and a negedge monitor checks every cycle of each run.
module tb_cpu_run_monitor;

  localparam int NC   = 4;
  localparam int PW   = 16;
  localparam int RH   = 2;
  localparam int DR   = 1;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [NC-1:0][7:0]    h;
    logic [NC-1:0][PW-1:0] cpc;
    int                    lim;
    int                    t_end;
    logic                  tmo;
    int                    end_m;
    logic [NC-1:0]         mask;
    int                    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [CW-1:0] limit = '0;
  logic running, done, timed_out;
  logic [CW-1:0] cycle_count;
  logic [NC-1:0] halt_mask;
  logic [NC*PW-1:0] halt_pc;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  bit   mon_armed = 1'b0;
  int   mon_m = 0;
  exp_t mon_e;

  cpu_run_monitor_if #(.NUM_CORES(NC), .PC_W(PW)) cif();

  cpu_run_monitor #(
    .NUM_CORES(NC), .PC_W(PW), .RST_HOLD(RH), .DRAIN_CYCLES(DR), .CNT_W(CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .timeout_limit (limit),
    .core          (cif),
    .running       (running),
    .done          (done),
    .timed_out     (timed_out),
    .cycle_count   (cycle_count),
    .halt_mask     (halt_mask),
    .halt_pc       (halt_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Run outcome from the rules: the run ends at the latest halt if every core halts no later
  // than the limit, otherwise at the limit with a timeout.
  function automatic exp_t model(input exp_t ein);
    exp_t e = ein;
    int latest = 0;
    bit all = 1'b1;
    for (int i = 0; i < NC; i++) begin
      if (e.h[i] == 0) all = 1'b0;
      else if (int'(e.h[i]) > latest) latest = int'(e.h[i]);
    end
    if (all && (e.lim == 0 || latest <= e.lim)) begin
      e.t_end = latest;
      e.tmo   = 1'b0;
    end else begin
      e.t_end = e.lim;
      e.tmo   = 1'b1;
    end
    e.mask = '0;
    for (int i = 0; i < NC; i++) e.mask[i] = (e.h[i] != 0) && (int'(e.h[i]) <= e.t_end);
    e.cnt   = (e.t_end > CMAX) ? CMAX : e.t_end;
    e.end_m = RH + e.t_end + (e.tmo ? 0 : DR);
    return e;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_core_rst_n"}, cif.core_rst_n, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
    chk({tag, "_halt_mask"}, halt_mask, 0);
    chk({tag, "_halt_pc"}, halt_pc, 0);
  endtask

  // m counts edges since the edge that accepted start (that edge is m = 0).
  task automatic check_cycle(input exp_t e, input int m);
    int kk;
    logic [NC-1:0] xm;
    logic ex_run;
    kk = m - RH;
    if (kk < 0) kk = 0;
    if (kk > e.t_end) kk = e.t_end;
    for (int i = 0; i < NC; i++) xm[i] = (e.h[i] != 0) && (int'(e.h[i]) <= kk);
    ex_run = (m >= RH) && (m < e.end_m);
    chk("cyc_core_rst_n", cif.core_rst_n, ex_run);
    chk("cyc_running", running, ex_run);
    chk("cyc_done", done, m >= e.end_m);
    chk("cyc_timed_out", timed_out, (m >= e.end_m) && e.tmo);
    chk("cyc_halt_mask", halt_mask, xm);
    chk("cyc_cycle_count", cycle_count, (kk > CMAX) ? CMAX : kk);
  endtask

  task automatic final_check(input exp_t e, input int m);
    logic [NC*PW-1:0] xp;
    for (int i = 0; i < NC; i++) xp[i*PW +: PW] = e.mask[i] ? e.cpc[i] : '0;
    chk("done_latency", m, e.end_m);
    chk("done_timed_out", timed_out, e.tmo);
    chk("done_halt_mask", halt_mask, e.mask);
    chk("done_cycle_count", cycle_count, e.cnt);
    chk("done_halt_pc", halt_pc, xp);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_armed = 1'b0;
      end else if (!mon_armed) begin
        if (start && sb_q.size() > 0) begin
          mon_armed = 1'b1;
          mon_m = -1;
          mon_e = sb_q[0];
        end
      end else begin
        mon_m++;
        check_cycle(mon_e, mon_m);
        if (done) begin
          final_check(mon_e, mon_m);
          void'(sb_q.pop_front());
          mon_armed = 1'b0;
        end else if (mon_m > mon_e.end_m + 2) begin
          checks++;
          errors++;
          $display("FAIL done_missing actual=0 expected=done by edge %0d", mon_e.end_m);
          void'(sb_q.pop_front());
          mon_armed = 1'b0;
        end
      end
    end
  end

  task automatic run_case(input logic [NC-1:0][7:0] h, input logic [NC-1:0][PW-1:0] cpc,
                          input int lim, input bit mid_start, input int abort_k);
    exp_t e;
    int hold [NC];
    int k;
    int last;
    e = '0;
    e.h = h;
    e.cpc = cpc;
    e.lim = lim;
    if (abort_k == 0) begin
      e = model(e);
      sb_q.push_back(e);
      last = e.end_m + 4;
    end else begin
      last = RH + abort_k;
    end
    for (int i = 0; i < NC; i++) hold[i] = $urandom_range(1, 4);
    limit = CW'(lim);
    @(posedge clk); #1;
    start = 1'b1;
    cif.hlt = NC'($urandom);
    cif.pc  = {$urandom, $urandom};
    for (int j = 1; j <= last; j++) begin
      @(posedge clk); #1;
      k = j - RH;
      start = mid_start && (k == 3);
      for (int i = 0; i < NC; i++) begin
        if (k >= 1 && (abort_k != 0 || k <= e.t_end)) begin
          cif.hlt[i] = (h[i] != 0) && (k >= int'(h[i])) && (k < int'(h[i]) + hold[i]);
          cif.pc[i*PW +: PW] = (k == int'(h[i])) ? cpc[i] : PW'($urandom);
        end else begin
          cif.hlt[i] = 1'($urandom);
          cif.pc[i*PW +: PW] = PW'($urandom);
        end
      end
      if (abort_k != 0 && k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout actual=hung expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    logic [NC-1:0][7:0]    h;
    logic [NC-1:0][PW-1:0] cpc;
    int lim;
    bit any_never;
    cif.hlt = '0;
    cif.pc  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    run_case({8'd10, 8'd10, 8'd10, 8'd10}, {16'h0045, 16'h0044, 16'h0043, 16'h0042}, 0, 1'b0, 0);
    run_case({8'd0, 8'd0, 8'd0, 8'd0}, '0, 20, 1'b0, 0);
    run_case({8'd30, 8'd9, 8'd9, 8'd5}, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 0, 1'b1, 0);
    run_case({8'd15, 8'd15, 8'd15, 8'd15}, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 15, 1'b0, 0);
    run_case({8'd0, 8'd0, 8'd8, 8'd3}, {16'h0, 16'h0, 16'hBEEF, 16'hCAFE}, 12, 1'b0, 0);
    run_case({8'd70, 8'd70, 8'd70, 8'd70}, {16'hA0, 16'hA1, 16'hA2, 16'hA3}, 0, 1'b0, 0);
    run_case({8'd0, 8'd0, 8'd0, 8'd0}, '0, 0, 1'b0, 8);
    run_case({8'd1, 8'd1, 8'd1, 8'd1}, {16'h5555, 16'h6666, 16'h7777, 16'h8888}, 0, 1'b0, 0);
    run_case({8'd1, 8'd1, 8'd1, 8'd1}, {16'h0101, 16'h0202, 16'h0303, 16'h0404}, 0, 1'b0, 0);

    for (int r = 0; r < 20; r++) begin
      any_never = 1'b0;
      for (int i = 0; i < NC; i++) begin
        h[i] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
        cpc[i] = PW'($urandom);
        if (h[i] == 0) any_never = 1'b1;
      end
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, CMAX);
      if (any_never && lim == 0) lim = $urandom_range(1, CMAX);
      run_case(h, cpc, lim, ($urandom_range(0, 3) == 0), 0);
    end

    repeat (4) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run controller for single- or multi-core CPU builds. It sequences the core reset, counts cycles, and detects per-core halts, capturing the PC of each core at its halt. It reports completion after a drain interval and flags a watchdog timeout. It replaces ad-hoc reset, halt and finish sequencing with a reusable block that works in benches and on FPGA alike.

Parameters:
NUM_CORES, 1, number of CPU cores monitored (1..16)
PC_W, 16, width of each core's PC
RST_HOLD, 2, cycles core_rst_n is held low per run (>=1)
DRAIN_CYCLES, 1, cycles waited after the last halt before done (>=0)
CNT_W, 32, width of cycle counter and timeout limit

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that launches a run
timeout_limit  input  CNT_W  watchdog limit in RUN cycles; 0 disables the watchdog
hlt  input  NUM_CORES  per-core halt level
pc  input  NUM_CORES*PC_W  per-core PC; core i occupies bits [i*PC_W +: PC_W]
core_rst_n  output  1  active-low reset to the cores
running  output  1  high in RUN and DRAIN
done  output  1  run finished, held until the next start
timed_out  output  1  run ended by the watchdog, held until the next start
cycle_count  output  CNT_W  RUN cycles elapsed, saturating
halt_mask  output  NUM_CORES  bit i set once core i has halted
halt_pc  output  NUM_CORES*PC_W  PC captured at each core's halt

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, core_rst_n = 0, running = 0, done = 0, timed_out = 0.
  - cycle_count, halt_mask and halt_pc are cleared to 0.
- States: IDLE, RESET, RUN, DRAIN, DONE. All outputs are registered.
- IDLE: core_rst_n = 0. On start, go to RESET; clear cycle_count, halt_mask, halt_pc, done and timed_out in that same edge.
- RESET: core_rst_n stays 0 for exactly RST_HOLD cycles (internal counter), then go to RUN. core_rst_n = 1 from the first RUN cycle.
- RUN:
  - cycle_count increments every cycle and saturates at all-ones; it does not wrap.
  - Per core: when hlt[i] = 1 and halt_mask[i] = 0, set halt_mask[i] and capture pc slice i into halt_pc slice i in the same edge.
  - Capture is level-based, so a core already high on its first RUN cycle is captured on that cycle. Later hlt drops are ignored and the mask is sticky.
  - When all mask bits are set (including bits set this cycle): if DRAIN_CYCLES = 0, go to DONE; otherwise go to DRAIN.
  - Watchdog: if timeout_limit != 0 and cycle_count + 1 >= timeout_limit on an edge where not all cores are halted, go to DONE with timed_out = 1.
  - If the halt condition and the timeout occur on the same edge, the halt wins and timed_out = 0.
- DRAIN: core_rst_n = 1; cycle_count frozen. After DRAIN_CYCLES cycles, go to DONE. Halts and timeout are ignored.
- DONE:
  - done = 1, running = 0, core_rst_n = 0 (cores held in reset).
  - Results stay stable until the next start, which behaves as in IDLE.
- start outside IDLE/DONE is ignored.
- Asserting rst_n mid-run aborts immediately to IDLE with all outputs at reset values.
- Latency from start to the first core_rst_n = 1 cycle is RST_HOLD + 1 edges.

Decomposition:
- Shared package cpu_pkg holds:
  - run_state_t enum (IDLE, RESET, RUN, DRAIN, DONE) and its encoding;
  - the default PC_W constant;
  - a helper that slices the PC for core i.
- One natural sub-module, halt_capture, instantiated NUM_CORES times: holds the sticky mask bit and the PC capture register for one core.
- The FSM, reset counter, drain counter and cycle counter stay in the top level.

Test Plan:
- NUM_CORES=1, RST_HOLD=2, DRAIN=1, limit 0; start; hlt rises on RUN cycle 10 with pc=16'h0042 -> core_rst_n low for 2 cycles, halt_mask=1, halt_pc=16'h0042, done after 1 drain cycle, cycle_count=10, timed_out=0.
- NUM_CORES=1, limit 20, hlt never rises -> after 20 RUN cycles: done=1, timed_out=1, halt_mask=0, cycle_count=20.
- NUM_CORES=4; cores halt on RUN cycles 5, 9, 9, 30 with PCs 0x10, 0x20, 0x30, 0x40 -> mask builds 0001, 0111, 1111; each halt_pc slice matches; done only after core 3 halts; cycle_count=30.
- Halt and timeout on the same edge (limit 15, hlt at RUN cycle 15) -> done=1, timed_out=0, halt_mask=1.
- CNT_W=4, limit 0, hlt held low for 20 cycles -> cycle_count saturates at 4'hF, no wrap; rst_n pulsed low mid-RUN -> immediate IDLE, all outputs 0.
- After DONE, second start with hlt already high on the first RUN cycle -> results cleared at start, captured on the first RUN cycle, done again; start pulsed mid-RUN is ignored.
